pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 131 +++++++++++++
 tb/tb_pll_reset_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: holds the 240 MHz domain in reset until the PLL lock flag
// has been stable for STABLE_CYCLES cycles, then holds for HOLD_CYCLES more
// cycles before releasing sys_rst_n and raising ready.
// Optional feature macro: PLL_RESET_SEQ_LOSS_CNT_EN enables the saturating
// lock-loss counter; without it lock_lost_count is tied to zero.
// The FSM state is exported on the state port for observation.
module pll_reset_seq #(
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic       clock_in,
  input  logic       resetb,
  input  logic       locked,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_lost_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic        w_cnt_clr;
  logic        r_sys_rst_n;
  logic        r_ready;

  // Two-flop synchronizer; r_sync2 is the only lock view the FSM uses.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      r_state <= WAIT_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a lock loss always wins over a terminal count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_LOCK: begin
        if (r_sync2) w_state_nxt = STABLE;
      end
      STABLE: begin
        if (!r_sync2)                 w_state_nxt = WAIT_LOCK;
        else if (r_cnt == STABLE_LAST) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (!r_sync2)               w_state_nxt = WAIT_LOCK;
        else if (r_cnt == HOLD_LAST) w_state_nxt = RUN;
      end
      RUN: begin
        if (!r_sync2) w_state_nxt = WAIT_LOCK;
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // Counter clears on any state change so each state starts counting at 0.
  assign w_cnt_clr = (w_state_nxt != r_state);

  // Shared cycle counter; only advances in the timed states.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= 16'd0;
    end else if (w_cnt_clr) begin
      r_cnt <= 16'd0;
    end else if ((r_state == STABLE) || (r_state == HOLD)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Outputs are registered from the next state so they move on the same
  // edge that enters or leaves RUN.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_sys_rst_n <= (w_state_nxt == RUN);
      r_ready     <= (w_state_nxt == RUN);
    end
  end

  assign sys_rst_n = r_sys_rst_n;
  assign ready     = r_ready;
  assign state     = r_state;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic       w_loss;
  logic [7:0] r_lost_cnt;

  assign w_loss = (r_state == RUN) && !r_sync2;

  // Saturating count of lock losses seen while running.
  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      r_lost_cnt <= 8'd0;
    end else if (w_loss && (r_lost_cnt != 8'hFF)) begin
      r_lost_cnt <= r_lost_cnt + 8'd1;
    end
  end

  assign lock_lost_count = r_lost_cnt;
`else
  assign lock_lost_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: randomized and directed lock patterns for pll_reset_seq,
// checked every cycle against a model based on how many consecutive
// synchronized-locked cycles have been seen.
`timescale 1ns/1ps
module tb_pll_reset_seq;

  localparam int S = 8;
  localparam int H = 4;

  // Clock and reset
  logic       clock_in = 1'b0;
  logic       resetb;
  logic       locked;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_lost_count;

  always #2 clock_in = ~clock_in;

  pll_reset_seq #(.STABLE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clock_in        (clock_in),
    .resetb          (resetb),
    .locked          (locked),
    .sys_rst_n       (sys_rst_n),
    .ready           (ready),
    .state           (state),
    .lock_lost_count (lock_lost_count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: m_k is the run length of consecutive locked_s=1
  // evaluations; the expected state follows from which window it sits in.
  int m_k    = 0;
  bit m_s1   = 1'b0;
  bit m_s2   = 1'b0;
  int m_lost = 0;
  bit saw_run = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_state();
    if (m_k == 0)          return 0;
    else if (m_k <= S)     return 1;
    else if (m_k <= S + H) return 2;
    else                   return 3;
  endfunction

  task automatic model_reset();
    m_k    = 0;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_lost = 0;
  endtask

  task automatic model_edge(input bit lk);
    if (m_s2) begin
      if (m_k < 1000000) m_k++;
    end else begin
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
      if ((m_k > S + H) && (m_lost < 255)) m_lost++;
`endif
      m_k = 0;
    end
    m_s2 = m_s1;
    m_s1 = lk;
  endtask

  task automatic check_all();
    int es;
    es = exp_state();
    chk("state", 16'(state), 16'(es));
    chk("sys_rst_n", 16'(sys_rst_n), 16'(es == 3));
    chk("ready", 16'(ready), 16'(es == 3));
    chk("lock_lost_count", 16'(lock_lost_count), 16'(m_lost));
    if (state == 2'd3) saw_run = 1'b1;
  endtask

  // Driver: one clock cycle with locked held at lk (called at a negedge).
  task automatic tick(input bit lk);
    locked = lk;
    @(posedge clock_in);
    model_edge(lk);
    @(negedge clock_in);
    check_all();
  endtask

  // Driver: a sub-period high pulse that no rising edge can capture.
  task automatic glitch();
    locked = 1'b0;
    #0.5 locked = 1'b1;
    #1   locked = 1'b0;
    @(posedge clock_in);
    model_edge(1'b0);
    @(negedge clock_in);
    check_all();
  endtask

  // Driver: mid-cycle reset pulse; outputs must clear before any edge.
  task automatic do_reset();
    #0.5 resetb = 1'b0;
    #0.5;
    model_reset();
    check_all();
    @(posedge clock_in);
    @(negedge clock_in);
    check_all();
    resetb = 1'b1;
  endtask

  // Edges from the first edge sampling locked=1 until sys_rst_n rises.
  task automatic relock_latency(input string tag);
    int n;
    n = 0;
    do begin
      tick(1'b1);
      n++;
    end while ((sys_rst_n !== 1'b1) && (n < 40));
    chk(tag, 16'(n - 1), 16'(2 + S + H));
  endtask

  // Edges from a lock drop until sys_rst_n falls.
  task automatic loss_latency(input string tag);
    int n;
    n = 0;
    do begin
      tick(1'b0);
      n++;
    end while ((sys_rst_n !== 1'b0) && (n < 10));
    chk(tag, 16'(n), 16'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b1;
    locked = 1'b0;
    @(negedge clock_in);
    do_reset();
    chk("reset_state", 16'(state), 16'd0);

    // Power-up: full sequence latency
    repeat (2) tick(1'b0);
    relock_latency("powerup_latency");

    // Loss in RUN, then relock
    loss_latency("run_loss_edges");
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    chk("run_loss_count", 16'(lock_lost_count), 16'd1);
`else
    chk("run_loss_count", 16'(lock_lost_count), 16'd0);
`endif
    repeat (2) tick(1'b0);
    relock_latency("relock_latency");

    // Dropout in STABLE at cnt=5: sequence restarts from scratch
    repeat (4) tick(1'b0);
    repeat (7) tick(1'b1);
    chk("stable_before_drop", 16'(state), 16'd1);
    repeat (3) tick(1'b0);
    relock_latency("stable_drop_relock");

    // Loss exactly at HOLD terminal count: RUN must never appear
    repeat (4) tick(1'b0);
    saw_run = 1'b0;
    repeat (12) tick(1'b1);
    repeat (4) tick(1'b0);
    chk("tc_loss_no_run", 16'(saw_run), 16'd0);
    chk("tc_loss_state", 16'(state), 16'd0);

    // Uncaptured glitches while waiting for lock
    repeat (5) glitch();
    chk("glitch_state", 16'(state), 16'd0);

    // Randomized lock patterns
    for (int seg = 0; seg < 300; seg++) begin
      int hi_len;
      int lo_len;
      hi_len = $urandom_range(1, 20);
      lo_len = $urandom_range(1, 4);
      for (int i = 0; i < hi_len; i++) tick(1'b1);
      for (int i = 0; i < lo_len; i++) begin
        if ($urandom_range(0, 7) == 0) glitch();
        else tick(1'b0);
      end
    end

    // Asynchronous reset while running
    repeat (3) tick(1'b0);
    repeat (16) tick(1'b1);
    chk("pre_reset_run", 16'(state), 16'd3);
    do_reset();
    chk("async_rst_sys_rst_n", 16'(sys_rst_n), 16'd0);
    chk("async_rst_count", 16'(lock_lost_count), 16'd0);

    // Saturation: 260 loss/relock cycles
    repeat (3) tick(1'b0);
    for (int r = 0; r < 260; r++) begin
      repeat (15) tick(1'b1);
      repeat (3) tick(1'b0);
    end
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    chk("saturation", 16'(lock_lost_count), 16'd255);
`else
    chk("saturation", 16'(lock_lost_count), 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
